// File: rtl/proc_pkg.sv
// Shared definitions for the 4-bit processor: opcodes, sequencer states,
// flag bit positions and instruction field layout.
`timescale 1ns/1ps
package proc_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_CMP = 4'h6;
    localparam logic [3:0] OP_LDI = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JEQ = 4'h9;
    localparam logic [3:0] OP_JLT = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int FLAG_LT     = 4;
    localparam int FLAG_GT     = 3;
    localparam int FLAG_EQ     = 2;
    localparam int FLAG_CARRY  = 1;
    localparam int FLAG_BORROW = 0;
    localparam logic [4:0] FLAG_VALID_MASK = 5'((1 << FLAG_LT) | (1 << FLAG_GT) |
        (1 << FLAG_EQ) | (1 << FLAG_CARRY) | (1 << FLAG_BORROW));

    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 4;
    localparam int IMM_MSB = 3;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALTED
    } seq_state_t;

    typedef enum logic [2:0] {
        CL_NOP, CL_ALU_ACC, CL_ALU_FLAG, CL_LDI, CL_JUMP, CL_HLT
    } op_class_t;

    // Reserved opcodes B-E fall into the default and run as NOP.
    function automatic op_class_t op_class(input logic [3:0] op);
        case (op)
            OP_NOP:                             return CL_NOP;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: return CL_ALU_ACC;
            OP_CMP:                             return CL_ALU_FLAG;
            OP_LDI:                             return CL_LDI;
            OP_JMP, OP_JEQ, OP_JLT:             return CL_JUMP;
            OP_HLT:                             return CL_HLT;
            default:                            return CL_NOP;
        endcase
    endfunction

endpackage

// File: rtl/seq_pc.sv
// Program counter register: clear to 0, load a jump target, or step by one
// with natural wrap at 2^PC_W.
`timescale 1ns/1ps
module seq_pc #(
    parameter int PC_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr,
    input  logic            inc,
    input  logic            load,
    input  logic [PC_W-1:0] load_val,
    output logic [PC_W-1:0] pc
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pc <= '0;
        else if (clr)
            pc <= '0;
        else if (load)
            pc <= load_val;
        else if (inc)
            pc <= pc + PC_W'(1);
    end

endmodule

// File: rtl/alu_sequencer.sv
// Fetch/decode/execute controller: owns the instruction ROM port and the ALU
// operands, holds IR, accumulator and captured flags.
`timescale 1ns/1ps
module alu_sequencer
    import proc_pkg::*;
#(
    parameter int PC_W    = 4,
    parameter int ALU_LAT = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            imem_en,
    output logic [PC_W-1:0] imem_addr,
    input  logic [7:0]      imem_data,
    output logic [3:0]      alu_opcode,
    output logic [3:0]      alu_a,
    output logic [3:0]      alu_b,
    input  logic [3:0]      alu_result,
    input  logic [4:0]      alu_flag,
    output logic [3:0]      acc,
    output logic [4:0]      flags,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            halted
);

    localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT + 1) : 1;

    seq_state_t       state;
    logic [7:0]       ir;
    logic [CNT_W-1:0] lat_cnt;
    logic [3:0]       ir_op, ir_imm, dec_op, dec_imm;
    logic             pc_clr, pc_inc, wb_jump;

    assign ir_op   = ir[OPC_MSB:OPC_LSB];
    assign ir_imm  = ir[IMM_MSB:IMM_LSB];
    assign dec_op  = imem_data[OPC_MSB:OPC_LSB];
    assign dec_imm = imem_data[IMM_MSB:IMM_LSB];

    // Conditional jumps test the flags captured by the last ALU writeback.
    assign wb_jump = (state == S_WB) &&
                     ((ir_op == OP_JMP) ||
                      (ir_op == OP_JEQ && flags[FLAG_EQ]) ||
                      (ir_op == OP_JLT && flags[FLAG_LT]));
    assign pc_inc  = (state == S_WB) && !wb_jump;
    assign pc_clr  = start && (state == S_IDLE || state == S_HALTED);
    assign imem_addr = pc;

    seq_pc #(.PC_W(PC_W)) u_pc (
        .clk      (clk),
        .reset    (reset),
        .clr      (pc_clr),
        .inc      (pc_inc),
        .load     (wb_jump),
        .load_val (ir_imm[PC_W-1:0]),
        .pc       (pc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            ir         <= '0;
            acc        <= '0;
            flags      <= '0;
            lat_cnt    <= '0;
            imem_en    <= 1'b0;
            busy       <= 1'b0;
            halted     <= 1'b0;
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
        end else begin
            imem_en <= 1'b0;
            case (state)
                S_IDLE, S_HALTED: begin
                    if (start) begin
                        state   <= S_FETCH;
                        imem_en <= 1'b1;
                        busy    <= 1'b1;
                        halted  <= 1'b0;
                    end
                end
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    ir <= imem_data;
                    case (op_class(dec_op))
                        CL_ALU_ACC, CL_ALU_FLAG: begin
                            state      <= S_EXEC;
                            lat_cnt    <= CNT_W'(ALU_LAT - 1);
                            alu_opcode <= dec_op;
                            alu_a      <= acc;
                            alu_b      <= dec_imm;
                        end
                        CL_HLT: begin
                            state  <= S_HALTED;
                            busy   <= 1'b0;
                            halted <= 1'b1;
                        end
                        default: state <= S_WB;
                    endcase
                end
                // Operands stay stable for ALU_LAT cycles, then drop back to 0.
                S_EXEC: begin
                    if (lat_cnt == '0) begin
                        state      <= S_WB;
                        alu_opcode <= '0;
                        alu_a      <= '0;
                        alu_b      <= '0;
                    end else begin
                        lat_cnt <= lat_cnt - CNT_W'(1);
                    end
                end
                S_WB: begin
                    case (op_class(ir_op))
                        CL_ALU_ACC: begin
                            acc   <= alu_result;
                            flags <= alu_flag & FLAG_VALID_MASK;
                        end
                        CL_ALU_FLAG: flags <= alu_flag & FLAG_VALID_MASK;
                        CL_LDI:      acc   <= ir_imm;
                        default: ;
                    endcase
                    state   <= S_FETCH;
                    imem_en <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: synchronous ROM and pipelined ALU models around the
// DUT, directed programs plus random programs checked by an ISA interpreter.
`timescale 1ns/1ps
module tb_alu_sequencer;

    localparam int PC_W    = 4;
    localparam int ALU_LAT = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic            imem_en;
    logic [PC_W-1:0] imem_addr;
    logic [7:0]      imem_data = '0;
    logic [3:0]      alu_opcode, alu_a, alu_b, alu_result, acc;
    logic [4:0]      alu_flag, flags;
    logic [PC_W-1:0] pc;
    logic            busy, halted;

    int total = 0;
    int bad   = 0;

    logic [7:0] rom [16];
    logic [3:0] ref_acc   = '0;
    logic [4:0] ref_flags = '0;
    logic [8:0] alu_s1 = '0;
    logic [8:0] alu_s2 = '0;

    alu_sequencer #(.PC_W(PC_W), .ALU_LAT(ALU_LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .imem_en    (imem_en),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .alu_flag   (alu_flag),
        .acc        (acc),
        .flags      (flags),
        .pc         (pc),
        .busy       (busy),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    // {flags[4:0], result[3:0]}; flags = {lt, gt, eq, carry, borrow}
    function automatic logic [8:0] alu_f(input logic [3:0] op, input logic [3:0] a,
                                         input logic [3:0] b);
        logic [4:0] sum;
        logic [3:0] r;
        logic       lt, gt, eq, cy, bw;
        sum = {1'b0, a} + {1'b0, b};
        case (op)
            4'h1:    r = sum[3:0];
            4'h2:    r = a - b;
            4'h3:    r = a & b;
            4'h4:    r = a | b;
            4'h5:    r = a ^ b;
            4'h6:    r = a - b;
            default: r = '0;
        endcase
        lt = a < b;
        gt = a > b;
        eq = a == b;
        cy = (op == 4'h1) && sum[4];
        bw = (op == 4'h2 || op == 4'h6) && (a < b);
        return {lt, gt, eq, cy, bw, r};
    endfunction

    always @(posedge clk) begin
        if (imem_en) imem_data <= rom[imem_addr];
    end

    // Two-stage ALU: output valid once inputs were stable for ALU_LAT cycles.
    always @(posedge clk) begin
        alu_s1 <= alu_f(alu_opcode, alu_a, alu_b);
        alu_s2 <= alu_s1;
    end
    assign alu_result = alu_s2[3:0];
    assign alu_flag   = alu_s2[8:4];

    // Instruction-level interpreter: final acc/flags/pc and cycle count to HALTED.
    function automatic void ref_run(output logic [3:0] a_o, output logic [4:0] f_o,
                                    output logic [3:0] p_o, output int cyc, output bit done);
        logic [3:0] p, a, op, imm;
        logic [4:0] f;
        logic [8:0] r;
        p = '0; a = ref_acc; f = ref_flags; cyc = 0; done = 1'b0;
        for (int n = 0; n < 60 && !done; n++) begin
            op  = rom[p][7:4];
            imm = rom[p][3:0];
            if (op >= 4'h1 && op <= 4'h6) begin
                r = alu_f(op, a, imm);
                f = r[8:4];
                if (op != 4'h6) a = r[3:0];
                cyc += 3 + ALU_LAT;
                p = p + 4'd1;
            end else if (op == 4'hF) begin
                cyc += 2;
                done = 1'b1;
            end else begin
                cyc += 3;
                if (op == 4'h7) a = imm;
                if (op == 4'h8 || (op == 4'h9 && f[2]) || (op == 4'hA && f[4])) p = imm;
                else p = p + 4'd1;
            end
        end
        a_o = a; f_o = f; p_o = p;
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        ref_acc = '0;
        ref_flags = '0;
    endtask

    // Pulses start, optionally pulses it again at cycle busy_pulse, returns cycles to halted (-1 on timeout).
    task automatic run_prog(input int busy_pulse, output int cyc);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = -1;
        for (int k = 1; k <= 400; k++) begin
            start = (k == busy_pulse);
            @(posedge clk);
            #1;
            if (halted) begin
                cyc = k;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        int seen_en, reached;
        #2;
        total++;
        if ({imem_en, busy, halted, acc, flags, pc, imem_addr, alu_opcode, alu_a, alu_b} !== '0) begin
            bad++;
            $display("FAIL reset_init outputs: got en=%0b busy=%0b halted=%0b acc=%h flags=%h pc=%h op=%h want all 0",
                     imem_en, busy, halted, acc, flags, pc, alu_opcode);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        seen_en = 0;
        repeat (4) begin
            @(posedge clk);
            #1 if (imem_en) seen_en++;
        end
        total++;
        if (seen_en != 0) begin
            bad++;
            $display("FAIL reset_idle_no_fetch: got %0d imem_en cycles want 0", seen_en);
        end
        clear_rom();
        rom[0] = 8'h75; rom[1] = 8'h13; rom[2] = 8'hF0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        reached = 0;
        for (int k = 0; k < 30 && reached == 0; k++) begin
            @(posedge clk);
            #1 if (alu_opcode == 4'h1) reached = 1;
        end
        total++;
        if (reached != 1) begin
            bad++;
            $display("FAIL reset_reach_exec: got %0d want 1", reached);
        end
        #3 reset = 1'b0;
        #1;
        total++;
        if ({imem_en, busy, halted, acc, flags, pc, imem_addr, alu_opcode, alu_a, alu_b} !== '0) begin
            bad++;
            $display("FAIL reset_mid_exec outputs: got en=%0b busy=%0b halted=%0b acc=%h flags=%h pc=%h op=%h want all 0",
                     imem_en, busy, halted, acc, flags, pc, alu_opcode);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        seen_en = 0;
        repeat (5) begin
            @(posedge clk);
            #1 if (imem_en || busy) seen_en++;
        end
        total++;
        if (seen_en != 0) begin
            bad++;
            $display("FAIL reset_release_quiet: got %0d active cycles want 0", seen_en);
        end
        ref_acc = '0;
        ref_flags = '0;
    endtask

    task automatic test_arith();
        int cyc;
        clear_rom();
        rom[0] = 8'h75; rom[1] = 8'h13; rom[2] = 8'hF0;
        run_prog(-1, cyc);
        total++;
        if ({halted, busy, acc, pc} !== {1'b1, 1'b0, 4'h8, 4'h2}) begin
            bad++;
            $display("FAIL arith_state: got halted=%0b busy=%0b acc=%h pc=%h want 1 0 8 2", halted, busy, acc, pc);
        end
        total++;
        if (cyc != 10) begin
            bad++;
            $display("FAIL arith_cycles: got %0d want 10", cyc);
        end
        ref_acc = 4'h8;
        ref_flags = flags;
    endtask

    task automatic test_restart_retain();
        int cyc;
        clear_rom();
        rom[0] = 8'h11; rom[1] = 8'hF0;
        run_prog(-1, cyc);
        total++;
        if ({halted, acc, pc} !== {1'b1, 4'h9, 4'h1} || cyc != 7) begin
            bad++;
            $display("FAIL restart_retain: got halted=%0b acc=%h pc=%h cyc=%0d want 1 9 1 7", halted, acc, pc, cyc);
        end
        ref_acc = acc;
        ref_flags = flags;
    endtask

    task automatic test_borrow();
        int cyc;
        clear_rom();
        rom[0] = 8'h72; rom[1] = 8'h23; rom[2] = 8'hF0;
        run_prog(-1, cyc);
        total++;
        if ({acc, flags[0], pc} !== {4'hF, 1'b1, 4'h2}) begin
            bad++;
            $display("FAIL borrow: got acc=%h borrow=%0b pc=%h want f 1 2", acc, flags[0], pc);
        end
        total++;
        if (flags !== 5'b10000 + 5'b00001) begin
            bad++;
            $display("FAIL borrow_flags: got %b want 10001", flags);
        end
        ref_acc = acc;
        ref_flags = flags;
    endtask

    task automatic test_branch();
        int cyc;
        for (int v = 0; v < 2; v++) begin
            clear_rom();
            rom[0] = 8'h74; rom[1] = (v == 0) ? 8'h64 : 8'h65; rom[2] = 8'h96; rom[3] = 8'h71;
            rom[4] = 8'hF0; rom[5] = 8'h00; rom[6] = 8'h79; rom[7] = 8'hF0;
            run_prog(-1, cyc);
            total++;
            if (v == 0 && ({acc, pc} !== {4'h9, 4'h7} || cyc != 16)) begin
                bad++;
                $display("FAIL branch_taken: got acc=%h pc=%h cyc=%0d want 9 7 16", acc, pc, cyc);
            end else if (v == 1 && ({acc, pc} !== {4'h1, 4'h4} || cyc != 16)) begin
                bad++;
                $display("FAIL branch_fallthru: got acc=%h pc=%h cyc=%0d want 1 4 16", acc, pc, cyc);
            end
        end
        ref_acc = acc;
        ref_flags = flags;
    endtask

    task automatic test_start_busy();
        int cyc;
        clear_rom();
        rom[0] = 8'h75; rom[1] = 8'h13; rom[2] = 8'hF0;
        run_prog(3, cyc);
        total++;
        if ({halted, acc, pc} !== {1'b1, 4'h8, 4'h2} || cyc != 10) begin
            bad++;
            $display("FAIL start_busy_ignored: got halted=%0b acc=%h pc=%h cyc=%0d want 1 8 2 10", halted, acc, pc, cyc);
        end
        ref_acc = acc;
        ref_flags = flags;
    endtask

    task automatic test_random();
        logic [3:0] ea, ep, op;
        logic [4:0] ef;
        int ec, cyc;
        bit done;
        for (int it = 0; it < 12; it++) begin
            done = 1'b0;
            for (int tries = 0; tries < 500 && !done; tries++) begin
                for (int i = 0; i < 16; i++) begin
                    op = 4'($urandom_range(0, 15));
                    if ($urandom_range(0, 7) == 0) op = 4'hF;
                    rom[i] = {op, 4'($urandom_range(0, 15))};
                end
                ref_run(ea, ef, ep, ec, done);
            end
            if (!done) begin
                clear_rom();
                rom[0] = 8'hF0;
                ref_run(ea, ef, ep, ec, done);
            end
            run_prog(int'($urandom_range(2, 5)), cyc);
            total++;
            if ({acc, flags, pc} !== {ea, ef, ep} || cyc != ec) begin
                bad++;
                $display("FAIL random_%0d: got acc=%h flags=%b pc=%h cyc=%0d want acc=%h flags=%b pc=%h cyc=%0d",
                         it, acc, flags, pc, cyc, ea, ef, ep, ec);
            end
            ref_acc = ea;
            ref_flags = ef;
        end
    endtask

    task automatic test_wrap();
        int cyc, n;
        int addrs [7];
        int when  [7];
        clear_rom();
        rom[1] = 8'hF0;
        run_prog(-1, cyc);
        total++;
        if ({halted, pc} !== {1'b1, 4'h1} || cyc != 5) begin
            bad++;
            $display("FAIL wrap_sweep: got halted=%0b pc=%h cyc=%0d want 1 1 5", halted, pc, cyc);
        end
        clear_rom();
        rom[0] = 8'h8F;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            if (imem_en && n < 7) begin
                addrs[n] = int'(imem_addr);
                when[n] = k;
                n++;
            end
            @(posedge clk);
            #1;
        end
        total++;
        if (n != 7) begin
            bad++;
            $display("FAIL wrap_fetch_count: got %0d want 7", n);
        end
        for (int i = 0; i < n; i++) begin
            total++;
            if (addrs[i] != ((i % 2 == 0) ? 0 : 15) || (i > 0 && when[i] - when[i-1] != 3)) begin
                bad++;
                $display("FAIL wrap_fetch_%0d: got addr=%0d gap=%0d want addr=%0d gap=3",
                         i, addrs[i], (i > 0) ? when[i] - when[i-1] : 3, (i % 2 == 0) ? 0 : 15);
            end
        end
        do_reset();
    endtask

    initial begin
        clear_rom();
        test_reset();
        test_arith();
        test_restart_retain();
        test_borrow();
        test_branch();
        test_start_busy();
        test_random();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
